// File: rtl/oam_dma_ctrl_if.sv
// oam_dma_ctrl_if
//   Groups the CPU-side bus and the shared system-bus drive of the OAM DMA
//   controller.
//   slave  : the DMA controller side (takes CPU bus + bus_din, drives halt/bus)
//   master : the surrounding system (CPU core, memory, bench)
//   Signals:
//     cpu_ce      one-sys_clock strobe per CPU cycle
//     cpu_addr    CPU address bus
//     cpu_dout    CPU write data
//     cpu_rnw     CPU read/not-write
//     bus_din     read data returned from the shared system bus
//     cpu_halt    stalls the CPU while 1
//     bus_addr    shared bus address
//     bus_dout    shared bus write data
//     bus_rnw     shared bus read/not-write
//     dma_active  1 while the DMA owns the bus
interface oam_dma_ctrl_if;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rnw;
  logic [7:0]  bus_din;
  logic        cpu_halt;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_rnw;
  logic        dma_active;

  modport slave (
    input  cpu_ce, cpu_addr, cpu_dout, cpu_rnw, bus_din,
    output cpu_halt, bus_addr, bus_dout, bus_rnw, dma_active
  );

  modport master (
    output cpu_ce, cpu_addr, cpu_dout, cpu_rnw, bus_din,
    input  cpu_halt, bus_addr, bus_dout, bus_rnw, dma_active
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl
//   Sprite OAM DMA engine. A CPU write to DMA_REG_ADDR latches a source page,
//   halts the CPU, and copies {page,00}..{page,FF} to OAM_DATA_ADDR as 256
//   read/write pairs, one bus access per CPU cycle (cpu_ce).
//   Ports:
//     sys_clock  system clock, all state on its rising edge
//     rst        asynchronous active-low reset
//     dma        oam_dma_ctrl_if.slave (CPU bus in, shared bus out, halt)
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | bus passes through from the CPU, watching for the trigger
//   ST_HALT  | CPU stalled; waits for a CPU read cycle (writes can't stall)
//   ST_ALIGN | one dummy read so the first READ lands on a get cycle
//   ST_READ  | reads {page,idx} from the bus into data
//   ST_WRITE | writes data to the OAM data port, advances idx
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input logic           sys_clock,
  input logic           rst,
  oam_dma_ctrl_if.slave dma
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       parity_q, parity_d;
  logic       cpu_halt_q, cpu_halt_d;
  logic       dma_active_q, dma_active_d;

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    data_d   = data_q;
    parity_d = parity_q;

    if (dma.cpu_ce) begin
      // parity of the current CPU cycle: 0 = get, 1 = put
      parity_d = ~parity_q;
      case (state_q)
        ST_IDLE: begin
          if ((dma.cpu_addr == DMA_REG_ADDR) && !dma.cpu_rnw) begin
            page_d  = dma.cpu_dout;
            idx_d   = 8'h00;
            state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          // a put cycle now means the next cycle is a get: start reading
          if (dma.cpu_rnw) state_d = parity_q ? ST_READ : ST_ALIGN;
        end
        ST_ALIGN: state_d = ST_READ;
        ST_READ: begin
          data_d  = dma.bus_din;
          state_d = ST_WRITE;
        end
        ST_WRITE: begin
          idx_d   = idx_q + 8'd1;
          state_d = (idx_q == 8'hFF) ? ST_IDLE : ST_READ;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    cpu_halt_d   = (state_d != ST_IDLE);
    dma_active_d = (state_d == ST_ALIGN) || (state_d == ST_READ) ||
                   (state_d == ST_WRITE);
  end

  always_ff @(posedge sys_clock or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      page_q       <= 8'h00;
      idx_q        <= 8'h00;
      data_q       <= 8'h00;
      parity_q     <= 1'b0;
      cpu_halt_q   <= 1'b0;
      dma_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      parity_q     <= parity_d;
      cpu_halt_q   <= cpu_halt_d;
      dma_active_q <= dma_active_d;
    end
  end

  // Bus drive: passthrough unless the DMA owns the bus. ALIGN issues a
  // harmless read of the first source byte.
  always_comb begin
    dma.bus_addr = dma.cpu_addr;
    dma.bus_dout = dma.cpu_dout;
    dma.bus_rnw  = dma.cpu_rnw;
    if (dma_active_q) begin
      dma.bus_dout = data_q;
      if (state_q == ST_WRITE) begin
        dma.bus_addr = OAM_DATA_ADDR;
        dma.bus_rnw  = 1'b0;
      end else begin
        dma.bus_addr = {page_q, idx_q};
        dma.bus_rnw  = 1'b1;
      end
    end
  end

  assign dma.cpu_halt   = cpu_halt_q;
  assign dma.dma_active = dma_active_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;
  logic sys_clock = 1'b0;
  logic rst = 1'b0;

  oam_dma_ctrl_if bif ();

  oam_dma_ctrl #(
    .DMA_REG_ADDR (16'h4014),
    .OAM_DATA_ADDR(16'h2004)
  ) dut (
    .sys_clock(sys_clock),
    .rst      (rst),
    .dma      (bif)
  );

  always #5 sys_clock = ~sys_clock;

  // system memory seen by bus reads
  logic [7:0] mem [0:65535];
  assign bif.bus_din = mem[bif.bus_addr];

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;  // CPU cycles since reset release; even = get, odd = put

  logic        obs_halt, obs_active, obs_rnw;
  logic [15:0] obs_addr;
  logic [7:0]  obs_dout;

  logic [15:0] got_addr[$];
  logic        got_rnw[$];
  logic [7:0]  got_dout[$];
  int          halted;
  bit          timed_out;
  logic [15:0] last_a;

  function automatic logic [15:0] rnd_addr();
    return {1'b1, 15'($urandom)};
  endfunction

  // one CPU cycle: inputs set, one cpu_ce strobe, outputs sampled before the edge
  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic r);
    @(negedge sys_clock);
    bif.cpu_addr = a;
    bif.cpu_dout = d;
    bif.cpu_rnw  = r;
    @(negedge sys_clock);
    bif.cpu_ce = 1'b1;
    #1;
    obs_halt   = bif.cpu_halt;
    obs_active = bif.dma_active;
    obs_rnw    = bif.bus_rnw;
    obs_addr   = bif.bus_addr;
    obs_dout   = bif.bus_dout;
    @(posedge sys_clock);
    #1 bif.cpu_ce = 1'b0;
    cyc_cnt++;
  endtask

  // Pads idle reads so the cycle where HALT meets its first read has the
  // requested parity, then writes the page to $4014.
  task automatic trigger(input logic [7:0] page, input bit want_get, input int nw);
    repeat ($urandom_range(0, 3)) cpu_cycle(rnd_addr(), 8'h00, 1'b1);
    while (((cyc_cnt + 1 + nw) % 2) != (want_get ? 1 : 0))
      cpu_cycle(rnd_addr(), 8'h00, 1'b1);
    cpu_cycle(16'h4014, page, 1'b0);
  endtask

  // CPU keeps reading until the halt drops; records every DMA-owned access
  task automatic capture(input bit inject, input logic [7:0] inj_val);
    got_addr.delete();
    got_rnw.delete();
    got_dout.delete();
    halted    = 0;
    timed_out = 1'b1;
    for (int n = 0; n < 700; n++) begin
      logic [15:0] a;
      a = rnd_addr();
      if (inject && got_addr.size() >= 100 && got_addr.size() < 106) begin
        a = 16'h4014;
        cpu_cycle(a, inj_val, 1'b0);
      end else begin
        cpu_cycle(a, 8'h00, 1'b1);
      end
      last_a = a;
      if (!obs_halt) begin
        timed_out = 1'b0;
        break;
      end
      halted++;
      if (obs_active) begin
        got_addr.push_back(obs_addr);
        got_rnw.push_back(obs_rnw);
        got_dout.push_back(obs_dout);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      bif.cpu_addr = 16'($urandom);
      bif.cpu_dout = 8'($urandom);
      bif.cpu_rnw  = 1'($urandom);
      bif.cpu_ce   = 1'b1;
      @(negedge sys_clock);
      #1;
      checks++;
      if (bif.cpu_halt !== 1'b0 || bif.dma_active !== 1'b0 || bif.bus_addr !== bif.cpu_addr ||
          bif.bus_dout !== bif.cpu_dout || bif.bus_rnw !== bif.cpu_rnw) begin
        failures++;
        $display("FAIL reset_state halt=%b active=%b bus=%h/%h/%b required halt=0 active=0 bus=%h/%h/%b",
                 bif.cpu_halt, bif.dma_active, bif.bus_addr, bif.bus_dout, bif.bus_rnw,
                 bif.cpu_addr, bif.cpu_dout, bif.cpu_rnw);
      end
    end
    bif.cpu_ce = 1'b0;
    @(negedge sys_clock);
    rst = 1'b1;
    cyc_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] a;
      logic [7:0]  d;
      logic        r;
      a = rnd_addr();
      d = 8'($urandom);
      r = 1'($urandom);
      cpu_cycle(a, d, r);
      checks++;
      if (obs_halt !== 1'b0 || obs_active !== 1'b0 || obs_addr !== a || obs_dout !== d || obs_rnw !== r) begin
        failures++;
        $display("FAIL idle_passthrough halt=%b active=%b bus=%h/%h/%b required halt=0 active=0 bus=%h/%h/%b",
                 obs_halt, obs_active, obs_addr, obs_dout, obs_rnw, a, d, r);
      end
    end
  endtask

  task automatic test_get_follow();
    logic [7:0] page;
    int bad, first_bad;
    page = 8'h02;
    trigger(page, 1'b1, 0);
    capture(1'b0, 8'h00);
    checks++;
    if (timed_out) begin failures++; $display("FAIL get_follow_timeout halted=%0d required end within 700", halted); end
    checks++;
    if (halted !== 513) begin failures++; $display("FAIL get_follow_halted got=%0d required=513", halted); end
    checks++;
    if (got_addr.size() != 512) begin
      failures++; $display("FAIL get_follow_accesses got=%0d required=512", got_addr.size());
    end else begin
      bad = 0; first_bad = 0;
      for (int i = 0; i < 256; i++) begin
        int rd;
        rd = 2 * i;
        if (got_addr[rd] !== {page, 8'(i)} || got_rnw[rd] !== 1'b1 || got_addr[rd+1] !== 16'h2004 ||
            got_rnw[rd+1] !== 1'b0 || got_dout[rd+1] !== mem[{page, 8'(i)}]) begin
          if (bad == 0) first_bad = i;
          bad++;
        end
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL get_follow_sequence bad_pairs=%0d first_idx=%0d required 0", bad, first_bad); end
    end
    checks++;
    if (obs_active !== 1'b0 || obs_addr !== last_a) begin
      failures++; $display("FAIL get_follow_release active=%b addr=%h required active=0 addr=%h", obs_active, obs_addr, last_a);
    end
  endtask

  task automatic test_align();
    logic [7:0] page;
    int bad, first_bad;
    page = 8'h02;
    trigger(page, 1'b0, 0);
    capture(1'b0, 8'h00);
    checks++;
    if (timed_out) begin failures++; $display("FAIL align_timeout halted=%0d required end within 700", halted); end
    checks++;
    if (halted !== 514) begin failures++; $display("FAIL align_halted got=%0d required=514", halted); end
    checks++;
    if (got_addr.size() != 513) begin
      failures++; $display("FAIL align_accesses got=%0d required=513", got_addr.size());
    end else begin
      checks++;
      if (got_rnw[0] !== 1'b1) begin failures++; $display("FAIL align_rnw got=%b required=1", got_rnw[0]); end
      bad = 0; first_bad = 0;
      for (int i = 0; i < 256; i++) begin
        int rd;
        rd = 2 * i + 1;
        if (got_addr[rd] !== {page, 8'(i)} || got_rnw[rd] !== 1'b1 || got_addr[rd+1] !== 16'h2004 ||
            got_rnw[rd+1] !== 1'b0 || got_dout[rd+1] !== mem[{page, 8'(i)}]) begin
          if (bad == 0) first_bad = i;
          bad++;
        end
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL align_sequence bad_pairs=%0d first_idx=%0d required 0", bad, first_bad); end
    end
  endtask

  task automatic test_halt_writes();
    logic [7:0] page;
    bit want_get;
    int off, bad, first_bad;
    page = 8'($urandom);
    want_get = 1'($urandom);
    off = want_get ? 0 : 1;
    trigger(page, want_get, 3);
    for (int i = 0; i < 3; i++) begin
      logic [15:0] a;
      logic [7:0]  d;
      a = rnd_addr();
      d = 8'($urandom);
      cpu_cycle(a, d, 1'b0);
      checks++;
      if (obs_halt !== 1'b1 || obs_active !== 1'b0 || obs_addr !== a || obs_dout !== d || obs_rnw !== 1'b0) begin
        failures++;
        $display("FAIL halt_write_%0d halt=%b active=%b bus=%h/%h/%b required halt=1 active=0 bus=%h/%h/0",
                 i, obs_halt, obs_active, obs_addr, obs_dout, obs_rnw, a, d);
      end
    end
    capture(1'b0, 8'h00);
    checks++;
    if (halted !== 513 + off) begin failures++; $display("FAIL halt_write_halted got=%0d required=%0d", halted, 513 + off); end
    checks++;
    if (got_addr.size() != 512 + off) begin
      failures++; $display("FAIL halt_write_accesses got=%0d required=%0d", got_addr.size(), 512 + off);
    end else begin
      bad = 0; first_bad = 0;
      for (int i = 0; i < 256; i++) begin
        int rd;
        rd = 2 * i + off;
        if (got_addr[rd] !== {page, 8'(i)} || got_rnw[rd] !== 1'b1 || got_addr[rd+1] !== 16'h2004 ||
            got_rnw[rd+1] !== 1'b0 || got_dout[rd+1] !== mem[{page, 8'(i)}]) begin
          if (bad == 0) first_bad = i;
          bad++;
        end
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL halt_write_sequence bad_pairs=%0d first_idx=%0d required 0", bad, first_bad); end
    end
  endtask

  task automatic test_retrigger_ignored();
    logic [7:0] page;
    bit want_get;
    int off, bad, first_bad, late;
    page = 8'($urandom);
    want_get = 1'($urandom);
    off = want_get ? 0 : 1;
    trigger(page, want_get, 0);
    capture(1'b1, page ^ 8'h5A);
    checks++;
    if (halted !== 513 + off) begin failures++; $display("FAIL retrigger_halted got=%0d required=%0d", halted, 513 + off); end
    checks++;
    if (got_addr.size() != 512 + off) begin
      failures++; $display("FAIL retrigger_accesses got=%0d required=%0d", got_addr.size(), 512 + off);
    end else begin
      bad = 0; first_bad = 0;
      for (int i = 0; i < 256; i++) begin
        int rd;
        rd = 2 * i + off;
        if (got_addr[rd] !== {page, 8'(i)} || got_rnw[rd] !== 1'b1 || got_addr[rd+1] !== 16'h2004 ||
            got_rnw[rd+1] !== 1'b0 || got_dout[rd+1] !== mem[{page, 8'(i)}]) begin
          if (bad == 0) first_bad = i;
          bad++;
        end
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL retrigger_sequence bad_pairs=%0d first_idx=%0d required 0", bad, first_bad); end
    end
    late = 0;
    for (int i = 0; i < 10; i++) begin
      cpu_cycle(rnd_addr(), 8'h00, 1'b1);
      if (obs_halt !== 1'b0) late++;
    end
    checks++;
    if (late != 0) begin failures++; $display("FAIL retrigger_no_restart halted_cycles=%0d required=0", late); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] page;
    bit found;
    int bad;
    page = 8'($urandom);
    trigger(page, 1'($urandom), 0);
    found = 1'b0;
    for (int n = 0; n < 700; n++) begin
      cpu_cycle(rnd_addr(), 8'h00, 1'b1);
      if (obs_active && obs_rnw && obs_addr == {page, 8'h80}) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL reset_mid_reach_idx80 found=0 required=1"); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bif.cpu_halt !== 1'b0 || bif.dma_active !== 1'b0 || bif.bus_addr !== bif.cpu_addr || bif.bus_rnw !== bif.cpu_rnw) begin
      failures++;
      $display("FAIL reset_mid_abort halt=%b active=%b addr=%h rnw=%b required halt=0 active=0 addr=%h rnw=%b",
               bif.cpu_halt, bif.dma_active, bif.bus_addr, bif.bus_rnw, bif.cpu_addr, bif.cpu_rnw);
    end
    @(negedge sys_clock);
    @(negedge sys_clock);
    rst = 1'b1;
    cyc_cnt = 0;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      cpu_cycle(rnd_addr(), 8'h00, 1'b1);
      if (obs_halt !== 1'b0 || obs_active !== 1'b0 || obs_rnw !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL reset_mid_no_resume bad_cycles=%0d required=0", bad); end
  endtask

  task automatic test_page_ff();
    int off, bad, first_bad, zero_hits;
    bit want_get;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
    want_get = 1'($urandom);
    off = want_get ? 0 : 1;
    trigger(8'hFF, want_get, 0);
    capture(1'b0, 8'h00);
    checks++;
    if (halted !== 513 + off) begin failures++; $display("FAIL page_ff_halted got=%0d required=%0d", halted, 513 + off); end
    zero_hits = 0;
    foreach (got_addr[i]) if (got_addr[i] == 16'h0000) zero_hits++;
    checks++;
    if (zero_hits != 0) begin failures++; $display("FAIL page_ff_wrap_access hits_0000=%0d required=0", zero_hits); end
    checks++;
    if (got_addr.size() != 512 + off) begin
      failures++; $display("FAIL page_ff_accesses got=%0d required=%0d", got_addr.size(), 512 + off);
    end else begin
      bad = 0; first_bad = 0;
      for (int i = 0; i < 256; i++) begin
        int rd;
        rd = 2 * i + off;
        if (got_addr[rd] !== {8'hFF, 8'(i)} || got_rnw[rd] !== 1'b1 || got_addr[rd+1] !== 16'h2004 ||
            got_rnw[rd+1] !== 1'b0 || got_dout[rd+1] !== 8'(i)) begin
          if (bad == 0) first_bad = i;
          bad++;
        end
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL page_ff_sequence bad_pairs=%0d first_idx=%0d required 0", bad, first_bad); end
      checks++;
      if (got_addr[510 + off] !== 16'hFFFF) begin
        failures++; $display("FAIL page_ff_last_read got=%h required=ffff", got_addr[510 + off]);
      end
      checks++;
      if (got_dout[511 + off] !== 8'hFF) begin
        failures++; $display("FAIL page_ff_last_data got=%h required=ff", got_dout[511 + off]);
      end
    end
  endtask

  initial begin
    bif.cpu_ce   = 1'b0;
    bif.cpu_addr = 16'h0000;
    bif.cpu_dout = 8'h00;
    bif.cpu_rnw  = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge sys_clock);
    test_reset();
    test_get_follow();
    test_align();
    test_halt_writes();
    test_retrigger_ignored();
    test_reset_mid();
    test_page_ff();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL expose parameter DMA_REG_ADDR, default 16'h4014, the CPU address whose write starts a DMA.
REQ-002 SHALL expose parameter OAM_DATA_ADDR, default 16'h2004, the PPU OAM data port written by DMA.
REQ-003 SHALL have port sys_clock  in  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; asynchronous and active-low (0 = reset).
REQ-005 SHALL have port cpu_ce  in  1  one-sys_clock strobe per CPU cycle (driven from clk_ph1); the FSM advances only when cpu_ce=1.
REQ-006 SHALL have ports cpu_addr  in  16, cpu_dout  in  8, and cpu_rnw  in  1: the CPU address bus, data out and read/not-write.
REQ-007 SHALL have port bus_din  in  8  read data returned from the shared system bus.
REQ-008 SHALL have port cpu_halt  out  1  stalls the CPU (RDY low equivalent) while 1.
REQ-009 SHALL have ports bus_addr  out  16, bus_dout  out  8, and bus_rnw  out  1: the shared system bus drive.
REQ-010 SHALL have port dma_active  out  1  1 while DMA owns the bus.

Function
REQ-011 States SHALL be IDLE, HALT, ALIGN, READ and WRITE; state, page[7:0], idx[7:0], data[7:0] and parity are registers.
REQ-012 parity SHALL toggle on every cpu_ce (0 = get cycle, 1 = put cycle), independent of state.
REQ-013 IDLE: on cpu_ce with cpu_addr==DMA_REG_ADDR and cpu_rnw==0 -> page<=cpu_dout, idx<=0, go HALT.
REQ-014 HALT: cpu_halt=1; on cpu_ce with cpu_rnw==1 -> go READ if parity==1 (next cycle is get), else go ALIGN; on cpu_ce with cpu_rnw==0 -> stay HALT (CPU write cycles cannot be stalled).
REQ-015 ALIGN: one dummy cycle; on cpu_ce -> READ.
REQ-016 READ: drive bus_addr={page,idx} and bus_rnw=1; on cpu_ce -> data<=bus_din, go WRITE.
REQ-017 WRITE: drive bus_addr=OAM_DATA_ADDR, bus_dout=data and bus_rnw=0; on cpu_ce -> idx<=idx+1 (8-bit); go IDLE if idx==8'hFF, else READ.
REQ-018 dma_active SHALL be 1 in ALIGN, READ and WRITE and 0 otherwise; when 0, bus_addr, bus_dout and bus_rnw SHALL pass through cpu_addr, cpu_dout and cpu_rnw combinationally.
REQ-019 cpu_halt SHALL be 1 in HALT, ALIGN, READ and WRITE and 0 in IDLE; cpu_halt SHALL deassert in the cycle after the 256th write completes.
REQ-020 Writes to DMA_REG_ADDR in any state other than IDLE SHALL be ignored; page SHALL not change mid-transfer.
REQ-021 Source addresses SHALL wrap within the page ({page,8'hFF} is followed by end of transfer, never {page+1,00}).
REQ-022 Total halted CPU cycles SHALL be 513 when the HALT cycle is followed by a get cycle, and 514 otherwise (one HALT + optional ALIGN + 512).
REQ-023 Page 8'h40 SHALL be treated as an ordinary page; no range checking SHALL be performed.

Reset
REQ-024 When rst==0, all registers SHALL clear asynchronously: state=IDLE, page=0, idx=0, data=0, parity=0.
REQ-025 When rst==0, the outputs SHALL be cpu_halt=0 and dma_active=0, with the bus in passthrough.
REQ-026 Reset asserted mid-transfer SHALL abort immediately; no further OAM writes; the next start requires a new $4014 write.

Verification
REQ-027 Bench SHALL cover: write 8'h02 to $4014, with the CPU reading during the halt, and the halt landing so that a get cycle follows -> 513 halted cycles; reads $0200..$02FF; 256 writes to $2004 with matching data.
REQ-028 Bench SHALL cover: same as REQ-027 but with the opposite parity -> exactly one ALIGN cycle, 514 halted cycles, and bus_rnw=1 on ALIGN.
REQ-029 Bench SHALL cover: CPU write cycles (cpu_rnw=0) for 3 cycles after the $4014 write -> stays in HALT for those cycles, passthrough is retained, and the transfer starts on the first read cycle.
REQ-030 Bench SHALL cover: rst pulled low at idx=8'h80 -> cpu_halt=0 and dma_active=0 in the same cycle; after release, no $2004 write occurs without a new trigger.
REQ-031 Bench SHALL cover: page 8'hFF, memory holding ascending bytes -> last read addr 16'hFFFF, the final write data equals mem[FFFF], and no access to 16'h0000.
REQ-032 Bench SHALL cover: a $4014 write issued during an active DMA (forced via the bus) -> ignored, and page is unchanged.
